// File: rtl/camo_key_array.sv
// Key-configurable array of NCELL 2-input cells (XOR/NAND/NOR) behind a serially loaded key.
// Optional macro CAMO_KEY_PARITY_EN appends an even-parity bit to the serial key.
module camo_key_array #(
    parameter int NCELL = 8,
    parameter int KLEN  = 2 * NCELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_sin,
    input  logic             key_sh,
    input  logic             key_commit,
    input  logic [NCELL-1:0] a_in,
    input  logic [NCELL-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NCELL-1:0] y_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             unlocked,
    output logic             key_err
);

`ifdef CAMO_KEY_PARITY_EN
    localparam int SLEN = KLEN + 1;
`else
    localparam int SLEN = KLEN;
`endif
    localparam int CW = $clog2(SLEN + 2);
    localparam logic [CW-1:0] SLEN_C  = CW'(SLEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(SLEN + 1);

    typedef enum logic [1:0] {
        S_LOCKED = 2'd0,
        S_LOAD   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SLEN-1:0]   r_shadow;
    logic [KLEN-1:0]   r_key;
    logic [CW-1:0]     r_count;
    logic              r_key_err;
    logic [NCELL-1:0]  r_y;
    logic              r_out_valid;
    logic [NCELL-1:0]  w_cell;
    logic              w_commit;
    logic              w_key_ok;
    logic              w_xfer;

    // A commit only counts in LOAD and loses to a simultaneous shift.
    assign w_commit = key_commit && !key_sh && (r_state == S_LOAD);

`ifdef CAMO_KEY_PARITY_EN
    assign w_key_ok = (r_count == SLEN_C) && !(^r_shadow);
`else
    assign w_key_ok = (r_count == SLEN_C);
`endif

    always_comb begin
        w_state_next = r_state;
        if (key_sh) begin
            w_state_next = S_LOAD;
        end else if (w_commit) begin
            w_state_next = w_key_ok ? S_ACTIVE : S_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_key     <= '0;
            r_count   <= '0;
            r_key_err <= 1'b0;
        end else if (key_sh) begin
            r_shadow <= {key_sin, r_shadow[SLEN-1:1]};
            if (r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_commit) begin
            r_count <= '0;
            if (w_key_ok) begin
                r_key     <= r_shadow[KLEN-1:0];
                r_key_err <= 1'b0;
            end else begin
                r_key     <= '0;
                r_key_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
            always_comb begin
                if (r_key[2*gi]) begin
                    w_cell[gi] = a_in[gi] ^ b_in[gi];
                end else if (r_key[2*gi+1]) begin
                    w_cell[gi] = ~(a_in[gi] | b_in[gi]);
                end else begin
                    w_cell[gi] = ~(a_in[gi] & b_in[gi]);
                end
            end
        end
    endgenerate

    assign unlocked = (r_state == S_ACTIVE);
    assign in_ready = unlocked && (!r_out_valid || out_ready);
    assign w_xfer   = in_valid && in_ready;

    // Anything that leaves (or stays out of) ACTIVE flushes the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_state_next != S_ACTIVE) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_y         <= w_cell;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign y_out     = r_y;
    assign out_valid = r_out_valid;
    assign key_err   = r_key_err;

endmodule

// File: tb/tb_camo_key_array.sv
// Directed bench for camo_key_array (NCELL=8); honours CAMO_KEY_PARITY_EN when defined.
module tb_camo_key_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_sin;
    logic       key_sh;
    logic       key_commit;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y_out;
    logic       out_valid;
    logic       out_ready;
    logic       unlocked;
    logic       key_err;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [15:0] key;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  y;
    } vec_t;

    vec_t vecs[6];

    camo_key_array #(.NCELL(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_sin   (key_sin),
        .key_sh    (key_sh),
        .key_commit(key_commit),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .unlocked  (unlocked),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        key_sh  = 1'b1;
        key_sin = b;
        tick();
        key_sh  = 1'b0;
    endtask

    // Shifts nbits of k LSB first; a full load also gets its parity bit when enabled.
    task automatic load_key(input logic [15:0] k, input int nbits, input logic par_flip);
        for (int i = 0; i < nbits; i++) begin
            shift_bit(k[i]);
        end
`ifdef CAMO_KEY_PARITY_EN
        if (nbits == 16) shift_bit((^k) ^ par_flip);
`else
        if (par_flip) shift_bit(1'b0);
`endif
    endtask

    task automatic commit();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp, input string name);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_y"}, 32'(y_out), 32'(exp));
        $display("xfer %s a=%02h b=%02h y=%02h", name, a, b, y_out);
        tick();
        chk({name, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{key: 16'h5555, a: 8'hF0, b: 8'hCC, y: 8'h3C};
        vecs[1] = '{key: 16'h0000, a: 8'hF0, b: 8'hCC, y: 8'h3F};
        vecs[2] = '{key: 16'hAAAA, a: 8'hF0, b: 8'hCC, y: 8'h03};
        vecs[3] = '{key: 16'h00FF, a: 8'hAA, b: 8'h0F, y: 8'hF5};
        vecs[4] = '{key: 16'h5555, a: 8'h12, b: 8'h34, y: 8'h26};
        vecs[5] = '{key: 16'hAAAA, a: 8'h00, b: 8'h00, y: 8'hFF};

        rst_n = 1'b0; key_sin = 1'b0; key_sh = 1'b0; key_commit = 1'b0;
        a_in = '0; b_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        chk("rst_key_err", 32'(key_err), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_key(vecs[v].key, 16, 1'b0);
            commit();
            chk($sformatf("v%0d_unlocked", v), 32'(unlocked), 32'd1);
            chk($sformatf("v%0d_key_err", v), 32'(key_err), 32'd0);
            xfer(vecs[v].a, vecs[v].b, vecs[v].y, $sformatf("v%0d", v));
        end

        // Commit while ACTIVE is ignored.
        commit();
        chk("active_commit_unlocked", 32'(unlocked), 32'd1);
        chk("active_commit_err", 32'(key_err), 32'd0);

        // Short key rejected, then a full key recovers.
        load_key(16'h5555, 15, 1'b0);
        commit();
        chk("short_unlocked", 32'(unlocked), 32'd0);
        chk("short_key_err", 32'(key_err), 32'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("short_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        load_key(16'h5555, 16, 1'b0);
        commit();
        chk("recover_key_err", 32'(key_err), 32'd0);
        chk("recover_unlocked", 32'(unlocked), 32'd1);
        $display("seq short-key reject/recover key_err=%0b unlocked=%0b", key_err, unlocked);

        // Output stall then back-to-back transfers.
        out_ready = 1'b0;
        a_in = 8'hF0; b_in = 8'hCC; in_valid = 1'b1;
        tick();
        a_in = 8'h12; b_in = 8'h34;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_y", c), 32'(y_out), 32'h3C);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            tick();
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("b2b0_y", 32'(y_out), 32'h26);
        a_in = 8'hFF; b_in = 8'h0F;
        tick();
        chk("b2b1_y", 32'(y_out), 32'hF0);
        chk("b2b1_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(out_valid), 32'd0);
        $display("seq stall/back-to-back done y=%02h", y_out);

        // Key shift while an output is pending flushes it.
        out_ready = 1'b0;
        a_in = 8'hF0; b_in = 8'hCC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("flush_pre_valid", 32'(out_valid), 32'd1);
        shift_bit(1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_unlocked", 32'(unlocked), 32'd0);
        chk("flush_y", 32'(y_out), 32'd0);
        commit();
        chk("flush_commit_err", 32'(key_err), 32'd1);
        $display("seq flush on key_sh done");

        // Shift and commit together: shift wins, commit ignored.
        load_key(16'h5555, 15, 1'b0);
        key_commit = 1'b1;
        shift_bit(1'b0);
        key_commit = 1'b0;
        chk("shcm_unlocked", 32'(unlocked), 32'd0);
        chk("shcm_key_err", 32'(key_err), 32'd1);
`ifdef CAMO_KEY_PARITY_EN
        shift_bit(1'b0);
`endif
        commit();
        chk("shcm_then_commit", 32'(unlocked), 32'd1);
        $display("seq shift+commit same cycle done");

        // Reset mid-load discards the partial count.
        load_key(16'h00FF, 8, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_unlocked", 32'(unlocked), 32'd0);
        load_key(16'h5555, 16, 1'b0);
        commit();
        chk("midrst_reload", 32'(unlocked), 32'd1);
        xfer(8'hF0, 8'hCC, 8'h3C, "midrst");

`ifdef CAMO_KEY_PARITY_EN
        load_key(16'h5555, 16, 1'b1);
        commit();
        chk("par_bad_unlocked", 32'(unlocked), 32'd0);
        chk("par_bad_err", 32'(key_err), 32'd1);
        load_key(16'h5555, 16, 1'b0);
        commit();
        chk("par_good_unlocked", 32'(unlocked), 32'd1);
        chk("par_good_err", 32'(key_err), 32'd0);
        $display("seq parity reject/accept done");
`else
        // A 17th bit overruns the expected length.
        load_key(16'h5555, 16, 1'b1);
        commit();
        chk("long_unlocked", 32'(unlocked), 32'd0);
        chk("long_key_err", 32'(key_err), 32'd1);
        $display("seq long-key reject done");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
